// File: rtl/axi_protocol_converter_v2_1_b2s_fifo_pkg.sv
// ---------------------------------------------------------------------------
// axi_protocol_converter_v2_1_b2s_fifo_pkg
// Shared definitions for the b2s handshake FIFO:
//   - clog2        : ceiling log2 used to size the shift-array read address
//   - CNT_RST_VAL  : fill-count value loaded by reset
//   - *_RST        : reset values of the registered status flags
//   - *_legal      : parameter-legality predicates evaluated at elaboration
// ---------------------------------------------------------------------------
package axi_protocol_converter_v2_1_b2s_fifo_pkg;

  localparam int CNT_RST_VAL = 0;

  localparam logic FULL_RST   = 1'b0;
  localparam logic AFULL_RST  = 1'b0;
  localparam logic EMPTY_RST  = 1'b1;
  localparam logic AEMPTY_RST = 1'b1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= 1) && (depth <= 64);
  endfunction

  // count must be able to represent C_DEPTH itself, not just C_DEPTH-1
  function automatic bit cnt_width_legal(input int cnt_width, input int depth);
    if (cnt_width >= 31) return 1'b1;
    if (cnt_width < 1) return 1'b0;
    return (1 << cnt_width) > depth;
  endfunction

  function automatic bit afull_legal(input int thresh, input int depth);
    return (thresh >= 1) && (thresh <= depth);
  endfunction

  function automatic bit aempty_legal(input int thresh, input int depth);
    return (thresh >= 0) && (thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/axi_protocol_converter_v2_1_b2s_srl_array.sv
// ---------------------------------------------------------------------------
// axi_protocol_converter_v2_1_b2s_srl_array
// C_WIDTH x C_DEPTH shift array with a random-access read tap. Written so it
// maps onto SRL primitives: no reset, single shift enable, mux read.
// Ports:
//   clk      in   clock
//   shift_en in   shift all entries up by one and load din into entry 0
//   din      in   C_WIDTH data shifted in
//   addr     in   C_AW read tap select (entry index)
//   dout     out  C_WIDTH contents of entry addr (combinational)
// ---------------------------------------------------------------------------
module axi_protocol_converter_v2_1_b2s_srl_array #(
  parameter int C_WIDTH = 8,
  parameter int C_DEPTH = 16,
  parameter int C_AW    = 4
) (
  input  logic               clk,
  input  logic               shift_en,
  input  logic [C_WIDTH-1:0] din,
  input  logic [C_AW-1:0]    addr,
  output logic [C_WIDTH-1:0] dout
);

  logic [C_WIDTH-1:0] r_mem [C_DEPTH];

  always_ff @(posedge clk) begin
    if (shift_en) r_mem[0] <= din;
  end

  genvar gi;
  generate
    for (gi = 1; gi < C_DEPTH; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (shift_en) r_mem[gi] <= r_mem[gi-1];
      end
    end

    if (C_DEPTH == 1) begin : g_single
      // only one entry, the address tap is meaningless
      assign dout = r_mem[0];
    end else begin : g_multi
      assign dout = r_mem[addr];
    end
  endgenerate

endmodule

// File: rtl/axi_protocol_converter_v2_1_b2s_hs_fifo.sv
// ---------------------------------------------------------------------------
// axi_protocol_converter_v2_1_b2s_hs_fifo
// Synchronous shift-register FIFO with valid/ready on both sides, used to
// carry AW/AR/B/R side information between b2s stages.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   s_valid  in   write request          s_ready out  write accepted
//   s_data   in   write data
//   m_valid  out  read data available    m_ready in   consumer takes data
//   m_data   out  oldest entry
//   count    out  registered fill level 0..C_DEPTH
//   full/a_full/empty/a_empty out  registered status flags
// Optional (macro B2S_FIFO_PEAK_EN):
//   peak_clr in   reload high-water mark with the next fill level
//   peak     out  registered high-water mark of count
// ---------------------------------------------------------------------------
module axi_protocol_converter_v2_1_b2s_hs_fifo
  import axi_protocol_converter_v2_1_b2s_fifo_pkg::*;
#(
  parameter int C_WIDTH         = 8,
  parameter int C_DEPTH         = 16,
  parameter int C_CNT_WIDTH     = 5,
  parameter int C_AFULL_THRESH  = 14,
  parameter int C_AEMPTY_THRESH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [C_WIDTH-1:0]     s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [C_WIDTH-1:0]     m_data,
`ifdef B2S_FIFO_PEAK_EN
  input  logic                   peak_clr,
  output logic [C_CNT_WIDTH-1:0] peak,
`endif
  output logic [C_CNT_WIDTH-1:0] count,
  output logic                   full,
  output logic                   a_full,
  output logic                   empty,
  output logic                   a_empty
);

  localparam int C_AW = (C_DEPTH > 1) ? clog2(C_DEPTH) : 1;
  localparam logic [C_CNT_WIDTH-1:0] LP_DEPTH  = C_CNT_WIDTH'(C_DEPTH);
  localparam logic [C_CNT_WIDTH-1:0] LP_AFULL  = C_CNT_WIDTH'(C_AFULL_THRESH);
  localparam logic [C_CNT_WIDTH-1:0] LP_AEMPTY = C_CNT_WIDTH'(C_AEMPTY_THRESH);
  localparam logic [C_CNT_WIDTH-1:0] LP_CNT_RST = C_CNT_WIDTH'(CNT_RST_VAL);

  generate
    if (!depth_legal(C_DEPTH)) begin : g_bad_depth
      $error("C_DEPTH must be in 1..64");
    end
    if (!cnt_width_legal(C_CNT_WIDTH, C_DEPTH)) begin : g_bad_cnt_width
      $error("C_CNT_WIDTH too small to hold C_DEPTH");
    end
    if (!afull_legal(C_AFULL_THRESH, C_DEPTH)) begin : g_bad_afull
      $error("C_AFULL_THRESH must be in 1..C_DEPTH");
    end
    if (!aempty_legal(C_AEMPTY_THRESH, C_DEPTH)) begin : g_bad_aempty
      $error("C_AEMPTY_THRESH must be in 0..C_DEPTH-1");
    end
  endgenerate

  logic [C_CNT_WIDTH-1:0] r_count;
  logic [C_CNT_WIDTH-1:0] w_count_next;
  logic                   r_full;
  logic                   r_a_full;
  logic                   r_empty;
  logic                   r_a_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [C_AW-1:0]        w_rd_addr;

  // s_ready is also gated by rst_n so nothing is written during reset
  assign s_ready = ~r_full & rst_n;
  assign m_valid = ~r_empty;
  assign w_push  = s_valid & s_ready;
  assign w_pop   = m_valid & m_ready;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + 1'b1;
    else if (!w_push && w_pop) w_count_next = r_count - 1'b1;
  end

  // oldest entry sits at count-1; clamp to 0 when empty (data is don't-care)
  assign w_rd_addr = (r_count == '0) ? '0 : C_AW'(r_count - 1'b1);

  // flags derive from the next count so they line up with the count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count   <= LP_CNT_RST;
      r_full    <= FULL_RST;
      r_a_full  <= AFULL_RST;
      r_empty   <= EMPTY_RST;
      r_a_empty <= AEMPTY_RST;
    end else begin
      r_count   <= w_count_next;
      r_full    <= (w_count_next == LP_DEPTH);
      r_a_full  <= (w_count_next >= LP_AFULL);
      r_empty   <= (w_count_next == '0);
      r_a_empty <= (w_count_next <= LP_AEMPTY);
    end
  end

  assign count   = r_count;
  assign full    = r_full;
  assign a_full  = r_a_full;
  assign empty   = r_empty;
  assign a_empty = r_a_empty;

  axi_protocol_converter_v2_1_b2s_srl_array #(
    .C_WIDTH (C_WIDTH),
    .C_DEPTH (C_DEPTH),
    .C_AW    (C_AW)
  ) u_srl_array (
    .clk      (clk),
    .shift_en (w_push),
    .din      (s_data),
    .addr     (w_rd_addr),
    .dout     (m_data)
  );

`ifdef B2S_FIFO_PEAK_EN
  logic [C_CNT_WIDTH-1:0] r_peak;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_peak <= '0;
    end else if (peak_clr) begin
      r_peak <= w_count_next;
    end else if (w_count_next > r_peak) begin
      r_peak <= w_count_next;
    end
  end

  assign peak = r_peak;
`endif

endmodule

// File: tb/tb_axi_protocol_converter_v2_1_b2s_hs_fifo.sv
// ---------------------------------------------------------------------------
// tb_axi_protocol_converter_v2_1_b2s_hs_fifo
// Self-checking bench: accepted writes are pushed to a scoreboard queue and
// popped/compared when the FIFO hands data out. Status outputs are checked
// against a bench-side fill-level model. Optional peak tests run when
// B2S_FIFO_PEAK_EN is defined.
// ---------------------------------------------------------------------------
module tb_axi_protocol_converter_v2_1_b2s_hs_fifo;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int CW = 5;
  localparam int AF = 14;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [CW-1:0] count;
  logic          full;
  logic          a_full;
  logic          empty;
  logic          a_empty;
`ifdef B2S_FIFO_PEAK_EN
  logic          peak_clr;
  logic [CW-1:0] peak;
`endif

  int n_vec = 0;
  int n_err = 0;
  int model_cnt = 0;
  logic [W-1:0] sb [$];

  always #5 clk = ~clk;

  axi_protocol_converter_v2_1_b2s_hs_fifo #(
    .C_WIDTH         (W),
    .C_DEPTH         (D),
    .C_CNT_WIDTH     (CW),
    .C_AFULL_THRESH  (AF),
    .C_AEMPTY_THRESH (AE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
`ifdef B2S_FIFO_PEAK_EN
    .peak_clr (peak_clr),
    .peak     (peak),
`endif
    .count    (count),
    .full     (full),
    .a_full   (a_full),
    .empty    (empty),
    .a_empty  (a_empty)
  );

  // One clock cycle of stimulus. Called #1 after a rising edge, returns #1
  // after the next rising edge. Handshake outputs are sampled mid-cycle.
  task automatic drive_cycle(input logic sv, input logic [W-1:0] sd, input logic mr);
    logic [W-1:0] exp_d;
    bit push_ok;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    #4;
    n_vec++;
    if (s_ready !== ((model_cnt < D) && rst_n)) begin
      n_err++;
      $display("FAIL s_ready: got %b want %b (model count %0d)", s_ready, (model_cnt < D) && rst_n, model_cnt);
    end
    n_vec++;
    if (m_valid !== (model_cnt > 0)) begin
      n_err++;
      $display("FAIL m_valid: got %b want %b (model count %0d)", m_valid, model_cnt > 0, model_cnt);
    end
    if (rst_n) begin
      push_ok = sv && (model_cnt < D);
      if (mr && model_cnt > 0) begin
        exp_d = sb.pop_front();
        n_vec++;
        if (m_data !== exp_d) begin
          n_err++;
          $display("FAIL pop_data: got %h want %h", m_data, exp_d);
        end else begin
          $display("pop  data=%h", m_data);
        end
        model_cnt--;
      end
      if (push_ok) begin
        sb.push_back(sd);
        model_cnt++;
        $display("push data=%h", sd);
      end
    end else begin
      sb.delete();
      model_cnt = 0;
      $display("reset cycle");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_cycle(1'b0, '0, 1'b0);
    drive_cycle(1'b1, 8'h77, 1'b0);
    rst_n = 1'b1;
    drive_cycle(1'b0, '0, 1'b0);
    n_vec++;
    if (count !== 5'd0 || empty !== 1'b1 || a_empty !== 1'b1 || full !== 1'b0 || a_full !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: got cnt=%0d e=%b ae=%b f=%b af=%b want cnt=0 e=1 ae=1 f=0 af=0",
               count, empty, a_empty, full, a_full);
    end
    n_vec++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs: got s_ready=%b m_valid=%b want 1 0", s_ready, m_valid);
    end
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    n_vec++;
    if (count !== 5'd5) begin
      n_err++;
      $display("FAIL pre_reset_count: got %0d want 5", count);
    end
    rst_n = 1'b0;
    drive_cycle(1'b1, 8'hEE, 1'b1);
    rst_n = 1'b1;
    n_vec++;
    if (count !== 5'd0 || m_valid !== 1'b0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: got cnt=%0d m_valid=%b empty=%b want 0 0 1", count, m_valid, empty);
    end
    drive_cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= D; i++) begin
      drive_cycle(1'b1, 8'(i), 1'b0);
      n_vec++;
      if (count !== CW'(i) || a_full !== (i >= AF) || full !== (i == D) || a_empty !== (i <= AE)) begin
        n_err++;
        $display("FAIL fill_%0d: got cnt=%0d af=%b f=%b ae=%b want cnt=%0d af=%b f=%b ae=%b",
                 i, count, a_full, full, a_empty, i, i >= AF, i == D, i <= AE);
      end
    end
    n_vec++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_s_ready: got %b want 0", s_ready);
    end
    drive_cycle(1'b1, 8'h99, 1'b0);
    n_vec++;
    if (count !== 5'd16) begin
      n_err++;
      $display("FAIL overflow_count: got %0d want 16", count);
    end
    for (int i = 0; i < D; i++) drive_cycle(1'b0, '0, 1'b1);
    n_vec++;
    if (count !== 5'd0 || empty !== 1'b1 || a_full !== 1'b0) begin
      n_err++;
      $display("FAIL drained: got cnt=%0d empty=%b af=%b want 0 1 0", count, empty, a_full);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, 8'(8'h40 + i), 1'b1);
      n_vec++;
      if (count !== 5'd8 || full !== 1'b0 || a_full !== 1'b0 || empty !== 1'b0 || a_empty !== 1'b0) begin
        n_err++;
        $display("FAIL stream_%0d: got cnt=%0d f=%b af=%b e=%b ae=%b want 8 0 0 0 0",
                 i, count, full, a_full, empty, a_empty);
      end
    end
    for (int i = 0; i < 8; i++) drive_cycle(1'b0, '0, 1'b1);
    n_vec++;
    if (count !== 5'd0) begin
      n_err++;
      $display("FAIL stream_drain: got %0d want 0", count);
    end
  endtask

  task automatic test_full_boundary();
    for (int i = 0; i < D; i++) drive_cycle(1'b1, 8'(8'h60 + i), 1'b0);
    drive_cycle(1'b1, 8'hF0, 1'b1);
    n_vec++;
    if (count !== 5'd15 || full !== 1'b0) begin
      n_err++;
      $display("FAIL full_pop: got cnt=%0d full=%b want 15 0", count, full);
    end
    drive_cycle(1'b1, 8'hF1, 1'b0);
    n_vec++;
    if (count !== 5'd16 || full !== 1'b1) begin
      n_err++;
      $display("FAIL full_refill: got cnt=%0d full=%b want 16 1", count, full);
    end
    for (int i = 0; i < D; i++) drive_cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_single();
    drive_cycle(1'b1, 8'hA5, 1'b0);
    n_vec++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || a_empty !== 1'b1 || count !== 5'd1) begin
      n_err++;
      $display("FAIL single: got mv=%b data=%h ae=%b cnt=%0d want 1 a5 1 1", m_valid, m_data, a_empty, count);
    end
    drive_cycle(1'b0, '0, 1'b1);
    n_vec++;
    if (empty !== 1'b1 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_pop: got empty=%b mv=%b want 1 0", empty, m_valid);
    end
  endtask

`ifdef B2S_FIFO_PEAK_EN
  task automatic test_peak();
    rst_n = 1'b0;
    drive_cycle(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    n_vec++;
    if (peak !== 5'd0) begin
      n_err++;
      $display("FAIL peak_reset: got %0d want 0", peak);
    end
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, '0, 1'b1);
    n_vec++;
    if (peak !== 5'd10) begin
      n_err++;
      $display("FAIL peak_hwm: got %0d want 10", peak);
    end
    peak_clr = 1'b1;
    drive_cycle(1'b0, '0, 1'b0);
    peak_clr = 1'b0;
    n_vec++;
    if (peak !== 5'd4) begin
      n_err++;
      $display("FAIL peak_clr: got %0d want 4", peak);
    end
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, 8'(8'h90 + i), 1'b0);
    n_vec++;
    if (peak !== 5'd6) begin
      n_err++;
      $display("FAIL peak_regrow: got %0d want 6", peak);
    end
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, '0, 1'b1);
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
`ifdef B2S_FIFO_PEAK_EN
    peak_clr = 1'b0;
`endif
    @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_boundary();
    test_single();
`ifdef B2S_FIFO_PEAK_EN
    test_peak();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
